// File: rtl/run_control_pkg.sv
// Shared types and defaults for the front-panel run-control block.
package run_control_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/run_control_if.sv
// Front-panel buttons, breakpoint/burst setup and the command/status outputs.
interface run_control_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BURST_WIDTH = 16
);
    logic                   btn_run;
    logic                   btn_halt;
    logic                   btn_step;
    logic                   bp_enable;
    logic [ADDR_WIDTH-1:0]  bp_addr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [BURST_WIDTH-1:0] burst_len;
    logic                   run;
    logic                   halt;
    logic                   step;
    logic                   running;
    logic                   break_hit;
    logic                   burst_done;

    modport master (
        output btn_run, btn_halt, btn_step, bp_enable, bp_addr, pc, burst_len,
        input  run, halt, step, running, break_hit, burst_done
    );

    modport slave (
        input  btn_run, btn_halt, btn_step, bp_enable, bp_addr, pc, burst_len,
        output run, halt, step, running, break_hit, burst_done
    );
endinterface

// File: rtl/run_control_button_debounce.sv
// One pushbutton: 2-flop synchroniser, debounce counter, rising-edge press pulse.
module button_debounce
    import run_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Synchronise, accept a new level after DEBOUNCE_CYCLES consecutive
    // differing samples, and register a one-cycle pulse on accepted rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/run_control.sv
// Run/halt/step command generator with breakpoint and burst auto-halt.
//
// state   | meaning
// STOPPED | processor clock held; run or step press accepted
// RUNNING | processor clocked; halt press, breakpoint or burst end stop it
module run_control
    import run_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ADDR_WIDTH      = 16,
    parameter int BURST_WIDTH     = 16
) (
    input  logic          clk,
    input  logic          reset,
    run_control_if.slave  bus
);
    logic press_run;
    logic press_halt;
    logic press_step;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk(clk), .reset(reset), .btn(bus.btn_run), .press(press_run)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_halt (
        .clk(clk), .reset(reset), .btn(bus.btn_halt), .press(press_halt)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .reset(reset), .btn(bus.btn_step), .press(press_step)
    );

    run_state_t             state;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [BURST_WIDTH-1:0] burst_cnt;
    logic                   burst_active;
    logic                   bp_armed;
    logic                   run_q;
    logic                   halt_q;
    logic                   step_q;
    logic                   break_hit_q;
    logic                   burst_done_q;
    logic                   bp_hit;
    logic                   burst_expire;

    // bp_armed only rises once pc has left bp_addr, so resuming from a
    // breakpoint does not immediately re-trigger on the same address.
    assign bp_hit       = bus.bp_enable & bp_armed & (pc_q == bus.bp_addr);
    assign burst_expire = burst_active & (burst_cnt == BURST_WIDTH'(1));

    // Run-control FSM with registered command pulses and sticky status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= STOPPED;
            pc_q         <= '0;
            burst_cnt    <= '0;
            burst_active <= 1'b0;
            bp_armed     <= 1'b0;
            run_q        <= 1'b0;
            halt_q       <= 1'b0;
            step_q       <= 1'b0;
            break_hit_q  <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            pc_q   <= bus.pc;
            run_q  <= 1'b0;
            halt_q <= 1'b0;
            step_q <= 1'b0;
            case (state)
                STOPPED: begin
                    if (press_run) begin
                        state        <= RUNNING;
                        run_q        <= 1'b1;
                        break_hit_q  <= 1'b0;
                        burst_done_q <= 1'b0;
                        burst_cnt    <= bus.burst_len;
                        burst_active <= (bus.burst_len != '0);
                        bp_armed     <= 1'b0;
                    end else if (press_step) begin
                        step_q       <= 1'b1;
                        break_hit_q  <= 1'b0;
                        burst_done_q <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (pc_q != bus.bp_addr) begin
                        bp_armed <= 1'b1;
                    end
                    if (burst_active) begin
                        burst_cnt <= burst_cnt - 1'b1;
                    end
                    if (press_halt) begin
                        state  <= STOPPED;
                        halt_q <= 1'b1;
                    end else if (bp_hit || burst_expire) begin
                        state  <= STOPPED;
                        halt_q <= 1'b1;
                        if (bp_hit) begin
                            break_hit_q <= 1'b1;
                        end
                        if (burst_expire) begin
                            burst_done_q <= 1'b1;
                        end
                    end
                end
                default: state <= STOPPED;
            endcase
        end
    end

    assign bus.run        = run_q;
    assign bus.halt       = halt_q;
    assign bus.step       = step_q;
    assign bus.running    = (state == RUNNING);
    assign bus.break_hit  = break_hit_q;
    assign bus.burst_done = burst_done_q;
endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control with DEBOUNCE_CYCLES=4.
module tb_run_control;
    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;
    int n_run    = 0;
    int n_halt   = 0;
    int n_step   = 0;
    int n_multi  = 0;
    int base_run;
    int base_halt;
    int base_step;

    run_control_if #(.ADDR_WIDTH(16), .BURST_WIDTH(16)) bus ();

    run_control #(
        .DEBOUNCE_CYCLES(4),
        .ADDR_WIDTH(16),
        .BURST_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count command pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.run)  n_run++;
        if (bus.halt) n_halt++;
        if (bus.step) n_step++;
        if ($countones({bus.run, bus.halt, bus.step}) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {bus.run, bus.halt, bus.step, bus.running, bus.break_hit, bus.burst_done};
    endfunction

    initial begin
        reset         = 1'b1;
        bus.btn_run   = 1'b0;
        bus.btn_halt  = 1'b0;
        bus.btn_step  = 1'b0;
        bus.bp_enable = 1'b0;
        bus.bp_addr   = 16'h0000;
        bus.pc        = 16'h0000;
        bus.burst_len = 16'h0000;
        tick(3);
        check("reset_outs", 32'(outs()), 0);
        reset = 1'b0;
        tick(2);

        // clean run press, then halt press
        base_run = n_run;
        bus.btn_run = 1'b1;
        tick(7);
        check("run_early", 32'(bus.run), 0);
        tick(1);
        check("run_latency", 32'(bus.run), 1);
        check("running_on", 32'(bus.running), 1);
        bus.btn_run = 1'b0;
        tick(12);
        check("run_single", 32'(n_run - base_run), 1);
        check("running_held", 32'(bus.running), 1);
        base_halt = n_halt;
        bus.btn_halt = 1'b1;
        tick(8);
        check("halt_pulse", 32'(bus.halt), 1);
        check("running_off", 32'(bus.running), 0);
        bus.btn_halt = 1'b0;
        tick(12);
        check("halt_single", 32'(n_halt - base_halt), 1);

        // bouncy step button
        base_step = n_step;
        for (int i = 0; i < 10; i++) begin
            bus.btn_step = ((i / 2) % 2 == 0);
            tick(1);
        end
        check("step_bounce_none", 32'(n_step - base_step), 0);
        bus.btn_step = 1'b1;
        tick(20);
        check("step_once", 32'(n_step - base_step), 1);
        tick(20);
        check("step_hold", 32'(n_step - base_step), 1);
        check("step_stopped", 32'(bus.running), 0);
        bus.btn_step = 1'b0;
        tick(12);

        // breakpoint on pc ramp
        bus.bp_enable = 1'b1;
        bus.bp_addr   = 16'h0010;
        bus.pc        = 16'h000C;
        base_halt = n_halt;
        bus.btn_run = 1'b1;
        tick(8);
        check("bp_run", 32'(bus.run), 1);
        bus.btn_run = 1'b0;
        for (int a = 13; a <= 16; a++) begin
            bus.pc = 16'(a);
            tick(1);
        end
        check("bp_not_yet", 32'({bus.running, bus.halt}), 32'h2);
        bus.pc = 16'h0011;
        tick(1);
        check("bp_halt", 32'({bus.running, bus.halt, bus.break_hit}), 32'h3);
        for (int a = 18; a <= 20; a++) begin
            bus.pc = 16'(a);
            tick(1);
        end
        tick(8);
        check("bp_halt_single", 32'(n_halt - base_halt), 1);

        // resume from breakpoint address
        bus.pc = 16'h0010;
        bus.btn_run = 1'b1;
        tick(8);
        check("rerun_run", 32'({bus.run, bus.break_hit}), 32'h2);
        bus.btn_run = 1'b0;
        tick(3);
        check("rerun_no_retrig", 32'({bus.running, bus.halt}), 32'h2);
        for (int a = 17; a <= 19; a++) begin
            bus.pc = 16'(a);
            tick(1);
        end
        check("rerun_still_run", 32'(bus.running), 1);
        bus.pc = 16'h0010;
        tick(1);
        check("rerun_match_wait", 32'(bus.halt), 0);
        tick(1);
        check("rerun_bp_halt", 32'({bus.running, bus.halt, bus.break_hit}), 32'h3);
        bus.bp_enable = 1'b0;
        tick(10);

        // burst of 5 cycles, burst_len changed mid-burst
        bus.burst_len = 16'd5;
        base_halt = n_halt;
        bus.btn_run = 1'b1;
        tick(8);
        check("burst_run", 32'({bus.run, bus.running, bus.break_hit}), 32'h6);
        bus.burst_len = 16'd2;
        bus.btn_run = 1'b0;
        tick(4);
        check("burst_mid", 32'({bus.running, bus.halt}), 32'h2);
        tick(1);
        check("burst_end", 32'({bus.running, bus.halt, bus.burst_done}), 32'h3);
        tick(10);
        check("burst_halt_single", 32'(n_halt - base_halt), 1);
        bus.burst_len = 16'd0;
        bus.btn_step = 1'b1;
        tick(8);
        check("step_clears_done", 32'({bus.step, bus.burst_done}), 32'h2);
        bus.btn_step = 1'b0;
        tick(12);

        // halt press coinciding with breakpoint match
        bus.bp_enable = 1'b1;
        bus.bp_addr   = 16'h0020;
        bus.pc        = 16'h0000;
        bus.btn_run = 1'b1;
        tick(8);
        check("prio_run", 32'(bus.run), 1);
        bus.btn_run = 1'b0;
        tick(12);
        base_halt = n_halt;
        bus.btn_halt = 1'b1;
        tick(6);
        bus.pc = 16'h0020;
        tick(1);
        check("prio_wait", 32'({bus.running, bus.halt}), 32'h2);
        tick(1);
        check("prio_halt", 32'({bus.running, bus.halt, bus.break_hit}), 32'h2);
        bus.btn_halt = 1'b0;
        tick(12);
        check("prio_halt_single", 32'(n_halt - base_halt), 1);
        bus.bp_enable = 1'b0;
        bus.pc = 16'h0000;

        // run and step together in STOPPED
        base_run  = n_run;
        base_step = n_step;
        bus.btn_run  = 1'b1;
        bus.btn_step = 1'b1;
        tick(8);
        check("both_run", 32'({bus.run, bus.step, bus.running}), 32'h5);
        bus.btn_step = 1'b0;
        tick(4);
        check("both_run_cnt", 32'(n_run - base_run), 1);
        check("both_step_cnt", 32'(n_step - base_step), 0);

        // reset while running, run button held through it
        base_halt = n_halt;
        reset = 1'b1;
        tick(1);
        check("rst_outs", 32'(outs()), 0);
        tick(1);
        reset = 1'b0;
        check("rst_no_halt", 32'(n_halt - base_halt), 0);
        tick(7);
        check("rst_rerun_early", 32'(bus.run), 0);
        tick(1);
        check("rst_rerun", 32'({bus.run, bus.running}), 32'h3);
        bus.btn_run = 1'b0;
        tick(12);

        check("no_overlap", 32'(n_multi), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
